// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the SimpleRisc fetch controller: state encodings,
// PC increment and the NOP encoding used by the instruction buffer.
package fetch_controller_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned PC_INC     = 4;

    // SimpleRisc nop: opcode 5'b01101, all other fields zero
    localparam logic [31:0] NOP_INST = 32'h6800_0000;

    typedef logic [2:0] fetchState_t;

    localparam fetchState_t StIdle = 3'd0;
    localparam fetchState_t StReq  = 3'd1;
    localparam fetchState_t StWait = 3'd2;
    localparam fetchState_t StHold = 3'd3;
    localparam fetchState_t StHalt = 3'd4;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/ack bus and decode valid/ready handshake of the
// fetch controller; master is the controller side.
interface fetch_controller_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              imem_req_out;
    logic [ADDR_W-1:0] imem_addr_out;
    logic              imem_ack_in;
    logic [INST_W-1:0] imem_data_in;
    logic              inst_valid_out;
    logic              inst_ready_in;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc_out;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ack_in,
        input  imem_data_in,
        output inst_valid_out,
        input  inst_ready_in,
        output inst_out,
        output inst_pc_out
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ack_in,
        output imem_data_in,
        input  inst_valid_out,
        output inst_ready_in,
        input  inst_out,
        input  inst_pc_out
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, redirect has priority
// over increment, otherwise hold.
module fetch_pc_reg
    import fetch_controller_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pcQ;

    // Increment wraps modulo 2^ADDR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcQ <= RESET_PC;
        end else if (redirect) begin
            pcQ <= {redirectPc[ADDR_W-1:2], 2'b00};
        end else if (inc) begin
            pcQ <= pcQ + ADDR_W'(PC_INC);
        end
    end

    assign pc = pcQ;

endmodule

// File: rtl/fetch_controller.sv
// SimpleRisc fetch sequencer: one outstanding imem request, branch redirect with
// stale-response squash, valid/ready to decode. FETCH_PERF_EN adds perf counters.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken_in,
    input  logic [ADDR_W-1:0] branch_pc_in,
    input  logic              halt_in,
    output logic              halted_out,
    fetch_controller_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt_out,
    output logic [15:0]       perf_squash_cnt_out
`endif
);

    fetchState_t       stateQ, stateD;
    logic              squashQ, squashD;
    logic              haltPendQ, haltPendD;
    logic              validQ, validD;
    logic [INST_W-1:0] instQ, instD;
    logic [ADDR_W-1:0] instPcQ, instPcD;

    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              pcInc;
    logic              transfer;
    logic              ackDrop;
    logic              haltNow;

    assign redirect = branch_taken_in && (stateQ != StHalt);
    assign transfer = (stateQ == StHold) && validQ && bus.inst_ready_in;
    assign haltNow  = haltPendQ || halt_in;
    // A branch coinciding with the ack kills that response without arming squash
    assign ackDrop  = (stateQ == StWait) && bus.imem_ack_in && (squashQ || branch_taken_in);
    assign pcInc    = (stateQ == StWait) && bus.imem_ack_in && !squashQ && !branch_taken_in;

    fetch_pc_reg #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .redirect  (redirect),
        .redirectPc(branch_pc_in),
        .inc       (pcInc),
        .pc        (pc)
    );

    always_comb begin
        stateD    = stateQ;
        squashD   = squashQ;
        haltPendD = haltNow;
        validD    = validQ;
        instD     = instQ;
        instPcD   = instPcQ;
        case (stateQ)
            StIdle: stateD = StReq;
            StReq: begin
                stateD = StWait;
                if (branch_taken_in) squashD = 1'b1;
            end
            StWait: begin
                if (bus.imem_ack_in) begin
                    squashD = 1'b0;
                    if (ackDrop) begin
                        stateD = StReq;
                    end else begin
                        validD  = 1'b1;
                        instD   = bus.imem_data_in;
                        instPcD = pc;
                        stateD  = StHold;
                    end
                end else if (branch_taken_in) begin
                    squashD = 1'b1;
                end
            end
            StHold: begin
                if (transfer) begin
                    validD = 1'b0;
                    stateD = haltNow ? StHalt : StReq;
                end else if (branch_taken_in) begin
                    validD = 1'b0;
                    stateD = StReq;
                end
            end
            StHalt: stateD = StHalt;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            squashQ   <= 1'b0;
            haltPendQ <= 1'b0;
            validQ    <= 1'b0;
            instQ     <= '0;
            instPcQ   <= '0;
        end else begin
            stateQ    <= stateD;
            squashQ   <= squashD;
            haltPendQ <= haltPendD;
            validQ    <= validD;
            instQ     <= instD;
            instPcQ   <= instPcD;
        end
    end

    assign bus.imem_req_out   = (stateQ == StReq);
    assign bus.imem_addr_out  = (stateQ == StReq) ? pc : '0;
    assign bus.inst_valid_out = validQ;
    assign bus.inst_out       = instQ;
    assign bus.inst_pc_out    = instPcQ;
    assign halted_out         = (stateQ == StHalt);

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCntQ;
    logic [15:0] squashCntQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCntQ  <= '0;
            squashCntQ <= '0;
        end else begin
            if (transfer && !(&fetchCntQ)) fetchCntQ <= fetchCntQ + 32'd1;
            if (ackDrop && !(&squashCntQ)) squashCntQ <= squashCntQ + 16'd1;
        end
    end

    assign perf_fetch_cnt_out  = fetchCntQ;
    assign perf_squash_cnt_out = squashCntQ;
`endif

endmodule
